// File: rtl/clock_alarm_unit.sv
// Alarm stage behind the time counters: alarm-time editing, match detection, ring/snooze/auto-stop and gated buzzer.
// Build option: define ALARM_SNOOZE_EN to include the SNOOZE state and snooze key handling.
module clock_alarm_unit #(
  parameter int unsigned TONE_DIV       = 12500,
  parameter int unsigned BEEP_HALF      = 25000000,
  parameter int unsigned RING_MINUTES   = 1,
  parameter int unsigned SNOOZE_MINUTES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       minute_tick,
  input  logic [3:0] min_lo,
  input  logic [3:0] min_hi,
  input  logic [3:0] hr_lo,
  input  logic [3:0] hr_hi,
  input  logic       key_set_p,
  input  logic       key_min_p,
  input  logic       key_hr_p,
  input  logic       key_stop_p,
  input  logic       key_snooze_p,
  output logic [3:0] alm_min_lo,
  output logic [3:0] alm_min_hi,
  output logic [3:0] alm_hr_lo,
  output logic [3:0] alm_hr_hi,
  output logic       setting,
  output logic       armed,
  output logic       ringing,
  output logic       buzzer
);

  localparam int unsigned TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned EW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    DISARMED,
    SET,
    ARMED,
    RINGING
`ifdef ALARM_SNOOZE_EN
    , SNOOZE
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] ring_cnt;
  logic [TW-1:0] tone_cnt;
  logic [EW-1:0] env_cnt;
  logic          tone;
  logic          env;
  logic          match_c;
  logic          ring_last_c;
  logic [7:0]    min_inc_c;
  logic [7:0]    hr_inc_c;

`ifdef ALARM_SNOOZE_EN
  logic [CW-1:0] snooze_cnt;
`else
  logic          unused_snooze_key;
  assign unused_snooze_key = key_snooze_p;
`endif

  // {setting, armed, ringing} for a given state
  function automatic logic [2:0] flags_of(input state_t s);
    case (s)
      SET:     flags_of = 3'b100;
      ARMED:   flags_of = 3'b010;
      RINGING: flags_of = 3'b011;
`ifdef ALARM_SNOOZE_EN
      SNOOZE:  flags_of = 3'b010;
`endif
      default: flags_of = 3'b000;
    endcase
  endfunction

  // Alarm is always legal BCD, so any non-BCD time digit simply fails the compare
  assign match_c = minute_tick && (min_lo == alm_min_lo) && (min_hi == alm_min_hi) &&
                   (hr_lo == alm_hr_lo) && (hr_hi == alm_hr_hi);
  assign ring_last_c = minute_tick && ((ring_cnt + CW'(1)) == CW'(RING_MINUTES));

  always_comb begin
    min_inc_c = {alm_min_hi, alm_min_lo};
    if (alm_min_lo == 4'd9) begin
      min_inc_c[3:0] = 4'd0;
      min_inc_c[7:4] = (alm_min_hi == 4'd5) ? 4'd0 : alm_min_hi + 4'd1;
    end else begin
      min_inc_c[3:0] = alm_min_lo + 4'd1;
    end
  end

  always_comb begin
    hr_inc_c = {alm_hr_hi, alm_hr_lo};
    if (alm_hr_hi == 4'd2 && alm_hr_lo == 4'd3) begin
      hr_inc_c = 8'h00;
    end else if (alm_hr_lo == 4'd9) begin
      hr_inc_c = {alm_hr_hi + 4'd1, 4'd0};
    end else begin
      hr_inc_c[3:0] = alm_hr_lo + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                       <= DISARMED;
      {setting, armed, ringing}   <= 3'b000;
      {alm_hr_hi, alm_hr_lo}      <= 8'h00;
      {alm_min_hi, alm_min_lo}    <= 8'h00;
      ring_cnt                    <= '0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt                  <= '0;
`endif
      tone_cnt                    <= '0;
      env_cnt                     <= '0;
      tone                        <= 1'b0;
      env                         <= 1'b1;
      buzzer                      <= 1'b0;
    end else begin
      buzzer <= 1'b0;

      // Tone and envelope run only while ringing; held at their start values otherwise
      if (state == RINGING) begin
        if (tone_cnt == TW'(TONE_DIV - 1)) begin
          tone_cnt <= '0;
          tone     <= ~tone;
        end else begin
          tone_cnt <= tone_cnt + TW'(1);
        end
        if (env_cnt == EW'(BEEP_HALF - 1)) begin
          env_cnt <= '0;
          env     <= ~env;
        end else begin
          env_cnt <= env_cnt + EW'(1);
        end
      end else begin
        tone_cnt <= '0;
        env_cnt  <= '0;
        tone     <= 1'b0;
        env      <= 1'b1;
      end

      case (state)
        DISARMED: begin
          if (key_set_p) begin
            state <= SET;
            {setting, armed, ringing} <= flags_of(SET);
          end
        end
        SET: begin
          if (key_min_p) {alm_min_hi, alm_min_lo} <= min_inc_c;
          if (key_hr_p)  {alm_hr_hi, alm_hr_lo}   <= hr_inc_c;
          if (key_set_p) begin
            state <= ARMED;
            {setting, armed, ringing} <= flags_of(ARMED);
          end
        end
        ARMED: begin
          if (key_set_p) begin
            state <= SET;
            {setting, armed, ringing} <= flags_of(SET);
          end else if (key_stop_p) begin
            state <= DISARMED;
            {setting, armed, ringing} <= flags_of(DISARMED);
          end else if (match_c) begin
            state    <= RINGING;
            ring_cnt <= '0;
            {setting, armed, ringing} <= flags_of(RINGING);
          end
        end
        RINGING: begin
          if (key_stop_p) begin
            state <= ARMED;
            {setting, armed, ringing} <= flags_of(ARMED);
`ifdef ALARM_SNOOZE_EN
          end else if (key_snooze_p) begin
            state      <= SNOOZE;
            snooze_cnt <= CW'(SNOOZE_MINUTES);
            {setting, armed, ringing} <= flags_of(SNOOZE);
`endif
          end else if (ring_last_c) begin
            state <= ARMED;
            {setting, armed, ringing} <= flags_of(ARMED);
          end else begin
            if (minute_tick) ring_cnt <= ring_cnt + CW'(1);
            buzzer <= tone & env;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (key_stop_p) begin
            state <= ARMED;
            {setting, armed, ringing} <= flags_of(ARMED);
          end else if (minute_tick) begin
            snooze_cnt <= snooze_cnt - CW'(1);
            if (snooze_cnt == CW'(1)) begin
              state    <= RINGING;
              ring_cnt <= '0;
              {setting, armed, ringing} <= flags_of(RINGING);
            end
          end
        end
`endif
        default: begin
          state <= DISARMED;
          {setting, armed, ringing} <= flags_of(DISARMED);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_alarm_unit.sv
// Directed bench for clock_alarm_unit with small tone/envelope divisors; follows ALARM_SNOOZE_EN like the RTL.
module tb_clock_alarm_unit;

  logic       clk;
  logic       rst;
  logic       minute_tick;
  logic [3:0] min_lo, min_hi, hr_lo, hr_hi;
  logic       key_set_p, key_min_p, key_hr_p, key_stop_p, key_snooze_p;
  logic [3:0] alm_min_lo, alm_min_hi, alm_hr_lo, alm_hr_hi;
  logic       setting, armed, ringing, buzzer;
  logic [15:0] alm;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] K_SET = 5'b10000;
  localparam logic [4:0] K_MIN = 5'b01000;
  localparam logic [4:0] K_HR  = 5'b00100;
  localparam logic [4:0] K_STP = 5'b00010;
  localparam logic [4:0] K_SNZ = 5'b00001;

  clock_alarm_unit #(
    .TONE_DIV(2), .BEEP_HALF(8), .RING_MINUTES(2), .SNOOZE_MINUTES(3)
  ) dut (
    .clk(clk), .rst(rst), .minute_tick(minute_tick),
    .min_lo(min_lo), .min_hi(min_hi), .hr_lo(hr_lo), .hr_hi(hr_hi),
    .key_set_p(key_set_p), .key_min_p(key_min_p), .key_hr_p(key_hr_p),
    .key_stop_p(key_stop_p), .key_snooze_p(key_snooze_p),
    .alm_min_lo(alm_min_lo), .alm_min_hi(alm_min_hi),
    .alm_hr_lo(alm_hr_lo), .alm_hr_hi(alm_hr_hi),
    .setting(setting), .armed(armed), .ringing(ringing), .buzzer(buzzer)
  );

  assign alm = {alm_hr_hi, alm_hr_lo, alm_min_hi, alm_min_lo};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] k);
    {key_set_p, key_min_p, key_hr_p, key_stop_p, key_snooze_p} = k;
    step();
    {key_set_p, key_min_p, key_hr_p, key_stop_p, key_snooze_p} = 5'b0;
  endtask

  task automatic tick_k(input logic [15:0] t, input logic [4:0] k);
    {hr_hi, hr_lo, min_hi, min_lo} = t;
    minute_tick = 1'b1;
    {key_set_p, key_min_p, key_hr_p, key_stop_p, key_snooze_p} = k;
    step();
    minute_tick = 1'b0;
    {key_set_p, key_min_p, key_hr_p, key_stop_p, key_snooze_p} = 5'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic set_alarm(input int h, input int m);
    pulse(K_SET);
    repeat (m) pulse(K_MIN);
    repeat (h) pulse(K_HR);
    pulse(K_SET);
  endtask

  // Buzzer after the k-th edge in RINGING: bit (k-1)%16 of 0x00CC
  logic [15:0] buz_pat;

  initial begin
    buz_pat = 16'h00CC;
    minute_tick = 1'b0;
    {hr_hi, hr_lo, min_hi, min_lo} = 16'h0000;
    {key_set_p, key_min_p, key_hr_p, key_stop_p, key_snooze_p} = 5'b0;

    // Reset state and key entry with wraps
    do_reset();
    check("rst_alarm", 32'(alm), 32'h0000);
    check("rst_flags", 32'({setting, armed, ringing, buzzer}), 32'h0);
    pulse(K_MIN);
    check("disarmed_ignores_min", 32'(alm), 32'h0000);
    pulse(K_SET);
    check("set_entered", 32'(setting), 32'h1);
    repeat (61) pulse(K_MIN);
    repeat (25) pulse(K_HR);
    pulse(K_SET);
    check("wrap_alarm", 32'(alm), 32'h0101);
    check("wrap_setting", 32'(setting), 32'h0);
    check("wrap_armed", 32'(armed), 32'h1);

    // Match detection and buzzer pattern
    do_reset();
    set_alarm(7, 30);
    check("alarm_0730", 32'(alm), 32'h0730);
    tick_k(16'h0729, 5'b0);
    check("no_ring_0729", 32'(ringing), 32'h0);
    tick_k(16'h073A, 5'b0);
    check("no_ring_nonbcd", 32'(ringing), 32'h0);
    tick_k(16'h0730, 5'b0);
    check("ring_0730", 32'(ringing), 32'h1);
    check("buzzer_entry", 32'(buzzer), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      step();
      check("buzzer_pattern", 32'(buzzer), 32'(buz_pat[4'((k - 1) % 16)]));
    end

    // Auto-stop after two unanswered minutes
    tick_k(16'h0731, 5'b0);
    check("ring_after_1min", 32'(ringing), 32'h1);
    tick_k(16'h0732, 5'b0);
    check("autostop_ringing", 32'(ringing), 32'h0);
    check("autostop_armed", 32'(armed), 32'h1);
    check("autostop_buzzer", 32'(buzzer), 32'h0);

    // Snooze (or its absence)
    tick_k(16'h0730, 5'b0);
    check("rering", 32'(ringing), 32'h1);
`ifdef ALARM_SNOOZE_EN
    pulse(K_SNZ);
    check("snooze_ringing", 32'(ringing), 32'h0);
    check("snooze_armed", 32'(armed), 32'h1);
    tick_k(16'h0731, 5'b0);
    tick_k(16'h0730, 5'b0);
    check("snooze_match_ignored", 32'(ringing), 32'h0);
    tick_k(16'h0733, 5'b0);
    check("snooze_expired", 32'(ringing), 32'h1);
    pulse(K_STP);
    check("snooze_stop_ringing", 32'(ringing), 32'h0);
    check("snooze_stop_armed", 32'(armed), 32'h1);
`else
    pulse(K_SNZ);
    check("snooze_ignored", 32'(ringing), 32'h1);
    tick_k(16'h0731, 5'b0);
    check("nosnz_ring_1min", 32'(ringing), 32'h1);
    tick_k(16'h0732, 5'b0);
    check("nosnz_autostop", 32'(ringing), 32'h0);
    check("nosnz_armed", 32'(armed), 32'h1);
`endif

    // Stop beats snooze; set beats match
    tick_k(16'h0730, 5'b0);
    check("ring_again", 32'(ringing), 32'h1);
    pulse(K_STP | K_SNZ);
    check("stop_prio_ringing", 32'(ringing), 32'h0);
    check("stop_prio_armed", 32'(armed), 32'h1);
    tick_k(16'h0731, 5'b0);
    tick_k(16'h0732, 5'b0);
    tick_k(16'h0733, 5'b0);
    check("no_snooze_rering", 32'(ringing), 32'h0);
    tick_k(16'h0730, K_SET);
    check("set_prio_setting", 32'(setting), 32'h1);
    check("set_prio_ringing", 32'(ringing), 32'h0);
    step();
    check("set_prio_still", 32'(ringing), 32'h0);
    pulse(K_MIN | K_HR);
    check("min_hr_same_cycle", 32'(alm), 32'h0831);
    pulse(K_STP);
    check("set_ignores_stop", 32'(setting), 32'h1);
    tick_k(16'h0831, 5'b0);
    check("set_ignores_tick", 32'({setting, ringing}), 32'h2);
    pulse(K_SET);
    check("rearmed", 32'(armed), 32'h1);

    // Reset while ringing
    tick_k(16'h0831, 5'b0);
    check("ring_0831", 32'(ringing), 32'h1);
    repeat (3) step();
    check("buzzer_high_before_rst", 32'(buzzer), 32'h1);
    rst = 1'b0;
    step();
    check("midrst_buzzer", 32'(buzzer), 32'h0);
    check("midrst_alarm", 32'(alm), 32'h0000);
    check("midrst_flags", 32'({setting, armed, ringing}), 32'h0);
    rst = 1'b1;

    // Stop while armed disarms
    pulse(K_SET);
    pulse(K_SET);
    check("armed_again", 32'(armed), 32'h1);
    pulse(K_STP);
    check("disarmed", 32'(armed), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_alarm_unit.md
Name: clock_alarm_unit

Overview:
Alarm stage that sits directly downstream of the digital-clock time counters. It consumes the four BCD time digits and a one-cycle minute-change strobe, and holds a user-set alarm time edited with debounced key pulses. On a time match it drives a gated-tone buzzer, with dismiss, snooze and auto-stop. It also exports the alarm digits so the display multiplexer can show them while the alarm is being set.

Parameters:
TONE_DIV, 12500, clk cycles per half-period of the buzzer tone (2 kHz at 50 MHz).
BEEP_HALF, 25000000, clk cycles per on/off half of the beep envelope (0.5 s).
RING_MINUTES, 1, minute strobes of unanswered ringing before auto-stop (1..15).
SNOOZE_MINUTES, 5, minute strobes spent in snooze before re-ringing (1..15).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-low reset.
minute_tick  in  1  one-cycle pulse; the time digits in that same cycle already hold the new minute.
min_lo, min_hi, hr_lo, hr_hi  in  4 each  current time, BCD.
key_set_p, key_min_p, key_hr_p, key_stop_p, key_snooze_p  in  1 each  debounced one-cycle key pulses.
alm_min_lo, alm_min_hi, alm_hr_lo, alm_hr_hi  out  4 each  alarm time, BCD.
setting  out  1  high in SET.
armed  out  1  high in ARMED, RINGING and SNOOZE.
ringing  out  1  high in RINGING.
buzzer  out  1  registered tone output.

Behaviour:
- Reset (rst low at a clk edge):
  - state DISARMED; alarm time 00:00.
  - All counters cleared; every 1-bit output 0.
- State outputs (setting, armed, ringing) are registered and follow the state.
- DISARMED:
  - key_set_p -> SET.
  - Other keys ignored.
- SET:
  - key_min_p: alarm minute +1 in BCD, 59 wraps to 00, no hour carry.
  - key_hr_p: alarm hour +1, 23 wraps to 00.
  - key_min_p and key_hr_p in the same cycle: both apply.
  - key_set_p -> ARMED.
  - key_stop_p, key_snooze_p and minute_tick are ignored in SET.
- ARMED:
  - key_set_p -> SET; takes priority over a match in the same cycle.
  - key_stop_p -> DISARMED.
  - Match: minute_tick high and all four time digits equal the alarm digits -> RINGING on the next edge; ring_cnt cleared.
- RINGING:
  - Priority: key_stop_p > key_snooze_p > auto-stop.
  - key_stop_p -> ARMED; re-rings the next day at the same time.
  - key_snooze_p -> SNOOZE; snooze_cnt loaded with SNOOZE_MINUTES.
  - Each minute_tick increments ring_cnt; when ring_cnt reaches RING_MINUTES -> ARMED.
- SNOOZE:
  - key_stop_p -> ARMED.
  - Each minute_tick decrements snooze_cnt; when the decrement reaches 0 -> RINGING, ring_cnt cleared.
  - A time match during SNOOZE is ignored.
- Buzzer generation:
  - Tone divider and envelope counter run only in RINGING; both are cleared, and tone=0, env=1, on the cycle RINGING is entered.
  - Tone toggles every TONE_DIV cycles.
  - env toggles every BEEP_HALF cycles.
  - buzzer register <= tone & env while in RINGING, else 0.
  - buzzer falls within 1 clk of leaving RINGING.
- Reset mid-operation: applies immediately on the next edge, including in RINGING (buzzer 0 one edge after rst sampled low).
- Time inputs are sampled only on minute_tick cycles; non-BCD time digits never match a legal alarm time.

Optional Feature:
ALARM_SNOOZE_EN:
- Defined: SNOOZE state and key_snooze_p behave as above.
- Undefined: SNOOZE state and snooze_cnt are not built; key_snooze_p is ignored in all states, and RINGING leaves only via key_stop_p or auto-stop.

Test Plan:
Bench parameters for all scenarios: TONE_DIV=2, BEEP_HALF=8, RING_MINUTES=2, SNOOZE_MINUTES=3.
1. Reset, then key_set_p, 61 x key_min_p, 25 x key_hr_p, key_set_p -> alarm reads 01:01; setting=0; armed=1.
2. Armed at 07:30; minute_tick with time 07:29 -> no ring. minute_tick with time 07:30 -> ringing=1 next cycle; buzzer toggles every 2 cycles for 8 cycles, then is 0 for 8 cycles, repeating.
3. Ringing, then two minute_ticks with no key -> state ARMED; ringing=0; buzzer=0 within 1 cycle.
4. Ringing, key_snooze_p -> ringing=0, armed=1. Three minute_ticks -> ringing=1 again. Then key_stop_p -> ARMED.
5. Ringing, key_stop_p and key_snooze_p in the same cycle -> ARMED, not SNOOZE. A match minute_tick in the same cycle as key_set_p while ARMED -> SET; no ring.
6. rst low during RINGING -> next edge: buzzer=0, alarm 00:00, state DISARMED. Repeat scenario 4 with ALARM_SNOOZE_EN undefined -> key_snooze_p has no effect; auto-stop after 2 ticks.
